ahb_fir_fifo: RTL and testbench
===============================

// Module: ahb_fir_fifo
// PURPOSE
//  Output buffer directly downstream of the AHB FIR stage. Captures each filtered sample
//  (out_wave/write_en) into a synchronous circular FIFO. The AHB-Lite slave port lets the
//  master pop samples, read status and issue flush/clear commands.
// PARAMETERS
//  DEPTH     16                    FIFO entries; power of two, >= 2, <= 255
//  OUT_SIZE  ahb_fir_pkg::OUT_SIZE  sample width from FIR, < DWIDTH
//  AWIDTH    ahb_fir_pkg::AWIDTH    AHB address width
//  DWIDTH    ahb_fir_pkg::DWIDTH    AHB data width (32)
// PORTS
//  clk        in   1         system clock, all logic on rising edge
//  rst_n      in   1         reset, synchronous, active-low
//  hsel       in   1         AHB slave select
//  haddr      in   AWIDTH    AHB address; only haddr[3:2] decoded
//  hsize      in   3         AHB size; ignored, all accesses treated as word
//  hwrite     in   1         AHB write strobe
//  htrans     in   2         AHB transfer type; htrans[1]=1 marks a valid transfer
//  hwdata     in   DWIDTH    AHB write data (data phase)
//  hready     in   1         AHB bus ready; address phase sampled only when 1
//  hreadyout  out  1         tied 1 (zero wait states)
//  hresp      out  1         tied 0 (OKAY)
//  hrdata     out  DWIDTH    AHB read data (data phase)
//  out_wave   in   OUT_SIZE  filtered sample from FIR
//  write_en   in   1         push strobe from FIR, one sample per cycle high
//  irq        out  1         threshold interrupt (only with AHB_FIR_FIFO_IRQ_EN)
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): rd_ptr=wr_ptr=count=0, overflow=underflow=0,
//   registered address phase cleared (htrans_1=0), hrdata=0, irq=0.
//   Storage array is not reset. Reset mid-transfer aborts it; no pop occurs.
//  AHB pipeline: hsel/haddr/hwrite/htrans are registered when hready=1.
//   Access valid in data phase = hsel_1 & htrans_1[1].
//  Address map (haddr[3:2]):
//   0 DATA    R: head sample sign-extended OUT_SIZE->DWIDTH; pop at end of data phase
//   1 STATUS  R: [0]empty [1]full [2]overflow [3]underflow [15:8]count, other bits 0
//   2 CTRL    W: hwdata[0]=flush, [1]=clear overflow, [2]=clear underflow; R returns 0
//   3 THRESH  R/W [7:0] irq level (IRQ build only; otherwise R=0, W ignored)
//  Read data: hrdata is combinational from the data-phase registers and current FIFO
//   state. Reads of unmapped words and writes to DATA/STATUS return 0 / have no effect.
//  Push: write_en=1 & !full -> mem[wr_ptr]<=out_wave, wr_ptr++, count++. Pointers are
//   $clog2(DEPTH) bits, wrap naturally; count is $clog2(DEPTH+1) bits.
//  Push while full: sample dropped, overflow<=1 (sticky), state unchanged.
//   Exception: a pop in the same cycle makes the push accepted (count stays DEPTH).
//  Pop while empty: hrdata=0, no pointer change, underflow<=1 (sticky).
//  Same-cycle push+pop when not empty: both occur; count unchanged.
//   When empty, the push proceeds and the pop is an underflow; bypass is not allowed.
//  Flush write: at end of CTRL data phase rd_ptr=wr_ptr=count=0. A push in that same
//   cycle is discarded (flush wins). The sticky flags are untouched unless bits [2:1] are set.
//  Sticky clear vs. new set in the same cycle: set wins.
//  Latency: a sample pushed at edge N is readable at DATA in a data phase after edge N.
// CONFIGURATION
//  `define AHB_FIR_FIFO_IRQ_EN:
//   - THRESH register exists (reset 0); irq is registered.
//   - irq = (count >= THRESH) & (THRESH != 0), updated one cycle after count changes.
//  Undefined:
//   - irq port absent; THRESH reads 0; no threshold logic synthesised.
// TESTING
//  1 Reset, read STATUS -> 0x0000_0001 (empty); read DATA -> 0, then STATUS bit3=1.
//  2 Push 3 samples (OUT_SIZE-bit -1, 5, 0x7FF.. max) -> STATUS count=3;
//    3 DATA reads return 0xFFFF_FFFF, 5, max in order; STATUS -> empty.
//  3 Push DEPTH+2 samples -> full=1, overflow=1, count=DEPTH;
//    reads return first DEPTH samples only; write CTRL=0x2 -> overflow=0.
//  4 Full FIFO, write_en held high while reading DATA back-to-back -> count stays DEPTH,
//    no overflow, data order preserved across pointer wrap.
//  5 Push 4, write CTRL=0x1 with write_en=1 same cycle -> count=0, empty=1,
//    pushed sample lost.
//  6 (IRQ_EN) THRESH=4, push 4 -> irq=1 one cycle after 4th push; one DATA pop -> irq=0.

Source files
------------

// File: rtl/ahb_fir_fifo.sv
// Circular sample FIFO behind the AHB FIR stage, drained through an AHB-Lite slave port.
// Optional threshold interrupt enabled by `define AHB_FIR_FIFO_IRQ_EN.
package ahb_fir_pkg;
  parameter int OUT_SIZE = 16;
  parameter int AWIDTH   = 32;
  parameter int DWIDTH   = 32;
endpackage

module ahb_fir_fifo #(
  parameter int DEPTH    = 16,
  parameter int OUT_SIZE = ahb_fir_pkg::OUT_SIZE,
  parameter int AWIDTH   = ahb_fir_pkg::AWIDTH,
  parameter int DWIDTH   = ahb_fir_pkg::DWIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       hsel,
  input  logic [AWIDTH-1:0]          haddr,
  input  logic [2:0]                 hsize,
  input  logic                       hwrite,
  input  logic [1:0]                 htrans,
  input  logic [DWIDTH-1:0]          hwdata,
  input  logic                       hready,
  output logic                       hreadyout,
  output logic                       hresp,
  output logic [DWIDTH-1:0]          hrdata,
  input  logic signed [OUT_SIZE-1:0] out_wave,
  input  logic                       write_en
`ifdef AHB_FIR_FIFO_IRQ_EN
  ,
  output logic                       irq
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_CTRL   = 2'd2;
  localparam logic [1:0] A_THRESH = 2'd3;

  function automatic logic [DWIDTH-1:0] sext(input logic signed [OUT_SIZE-1:0] s);
    return {{(DWIDTH - OUT_SIZE){s[OUT_SIZE-1]}}, s};
  endfunction

  logic signed [OUT_SIZE-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          overflow, underflow;

  logic          hsel_p1, hwrite_p1;
  logic [1:0]    htrans_p1, addr_p1;

  logic acc_p1, rd_done, wr_done, empty, full;
  logic pop_req, pop, push, flush, clr_ovf, clr_udf, ovf_set, udf_set;
  logic [DWIDTH-1:0] status;
  logic unused_ok;

  assign hreadyout = 1'b1;
  assign hresp     = 1'b0;
  assign unused_ok = ^{hsize, haddr, hwdata};

  // Address phase -> data phase registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hsel_p1   <= 1'b0;
      hwrite_p1 <= 1'b0;
      htrans_p1 <= 2'b00;
      addr_p1   <= 2'b00;
    end else if (hready) begin
      hsel_p1   <= hsel;
      hwrite_p1 <= hwrite;
      htrans_p1 <= htrans;
      addr_p1   <= haddr[3:2];
    end
  end

  assign acc_p1  = hsel_p1 & htrans_p1[1];
  assign rd_done = acc_p1 & ~hwrite_p1 & hready;
  assign wr_done = acc_p1 & hwrite_p1 & hready;
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));

  assign pop_req = rd_done & (addr_p1 == A_DATA);
  assign pop     = pop_req & ~empty;
  assign udf_set = pop_req & empty;
  assign flush   = wr_done & (addr_p1 == A_CTRL) & hwdata[0];
  assign clr_ovf = wr_done & (addr_p1 == A_CTRL) & hwdata[1];
  assign clr_udf = wr_done & (addr_p1 == A_CTRL) & hwdata[2];
  // A pop on the same edge frees the slot, so a push into a full FIFO is still taken.
  assign push    = write_en & (~full | pop) & ~flush;
  assign ovf_set = write_en & full & ~pop & ~flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
      overflow  <= ovf_set | (overflow & ~clr_ovf);
      underflow <= udf_set | (underflow & ~clr_udf);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= out_wave;
  end

`ifdef AHB_FIR_FIFO_IRQ_EN
  logic [7:0] thresh;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      thresh <= 8'd0;
      irq    <= 1'b0;
    end else begin
      if (wr_done && (addr_p1 == A_THRESH)) thresh <= hwdata[7:0];
      irq <= (8'(count) >= thresh) && (thresh != 8'd0);
    end
  end
`endif

  always_comb begin
    status        = '0;
    status[0]     = empty;
    status[1]     = full;
    status[2]     = overflow;
    status[3]     = underflow;
    status[8 +: CW] = count;
  end

  always_comb begin
    hrdata = '0;
    if (acc_p1 && !hwrite_p1) begin
      case (addr_p1)
        A_DATA:   if (!empty) hrdata = sext(mem[rd_ptr]);
        A_STATUS: hrdata = status;
`ifdef AHB_FIR_FIFO_IRQ_EN
        A_THRESH: hrdata = DWIDTH'(thresh);
`endif
        default:  hrdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_fir_fifo.sv
// Scoreboard bench for ahb_fir_fifo: queue-based reference model, randomized and directed traffic.
module tb_ahb_fir_fifo;
  localparam int DEPTH    = 16;
  localparam int OUT_SIZE = 16;
  localparam int AWIDTH   = 32;
  localparam int DWIDTH   = 32;

  logic clk, rst_n, hsel, hwrite, hready, hreadyout, hresp, write_en;
  logic [AWIDTH-1:0] haddr;
  logic [2:0] hsize;
  logic [1:0] htrans;
  logic [DWIDTH-1:0] hwdata, hrdata;
  logic signed [OUT_SIZE-1:0] out_wave;
`ifdef AHB_FIR_FIFO_IRQ_EN
  logic irq;
`endif

  ahb_fir_fifo #(.DEPTH(DEPTH), .OUT_SIZE(OUT_SIZE), .AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .hsel(hsel), .haddr(haddr), .hsize(hsize), .hwrite(hwrite),
    .htrans(htrans), .hwdata(hwdata), .hready(hready), .hreadyout(hreadyout), .hresp(hresp),
    .hrdata(hrdata), .out_wave(out_wave), .write_en(write_en)
`ifdef AHB_FIR_FIFO_IRQ_EN
    , .irq(irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [OUT_SIZE-1:0] mq[$];
  logic [DWIDTH-1:0] exp_q[$];
  bit m_ovf, m_udf, m_irq, m_init;
  int m_thr;
  bit dp_v, dp_w, dp_rd;
  int dp_a;

  task automatic check(input string name, input logic [DWIDTH-1:0] act, input logic [DWIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DWIDTH-1:0] expected_read(input int a);
    logic [DWIDTH-1:0] v;
    logic [OUT_SIZE-1:0] s;
    int sz;
    sz = mq.size();
    v = '0;
    case (a)
      0: if (sz > 0) begin
           s = mq[0];
           v = {{(DWIDTH-OUT_SIZE){s[OUT_SIZE-1]}}, s};
         end
      1: begin
           v[0] = (sz == 0);
           v[1] = (sz == DEPTH);
           v[2] = m_ovf;
           v[3] = m_udf;
           v[15:8] = 8'(sz);
         end
      3: v = DWIDTH'(m_thr);
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic model_step();
    int sz;
    bit rd, wr, pop_req, popped, flush, clr_o, clr_u, ovf_set, udf_set, irq_next;
    if (!rst_n) begin
      mq.delete();
      m_ovf = 0; m_udf = 0; m_thr = 0; m_irq = 0;
      dp_v = 0; dp_w = 0; dp_a = 0; dp_rd = 0;
      m_init = 1;
      return;
    end
    sz = mq.size();
    irq_next = (m_thr != 0) && (sz >= m_thr);
    rd = dp_v && !dp_w && hready;
    wr = dp_v && dp_w && hready;
    pop_req = rd && (dp_a == 0);
    popped  = pop_req && (sz > 0);
    udf_set = pop_req && (sz == 0);
    flush = wr && (dp_a == 2) && hwdata[0];
    clr_o = wr && (dp_a == 2) && hwdata[1];
    clr_u = wr && (dp_a == 2) && hwdata[2];
    if (popped) void'(mq.pop_front());
    if (flush) mq.delete();
    ovf_set = 0;
    if (write_en && !flush) begin
      if (sz < DEPTH || popped) mq.push_back(out_wave);
      else ovf_set = 1;
    end
    m_ovf = ovf_set || (m_ovf && !clr_o);
    m_udf = udf_set || (m_udf && !clr_u);
`ifdef AHB_FIR_FIFO_IRQ_EN
    if (wr && dp_a == 3) m_thr = int'(hwdata[7:0]);
    m_irq = irq_next;
`endif
    if (hready) begin
      dp_v = hsel && htrans[1];
      dp_w = hwrite;
      dp_a = int'(haddr[3:2]);
    end
    dp_rd = dp_v && !dp_w;
    if (dp_rd) exp_q.push_back(expected_read(dp_a));
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // monitor: compares whenever a read data phase is presented
  initial forever begin
    @(negedge clk);
    if (m_init) begin
      if (dp_rd) begin
        if (exp_q.size() == 0) check("scoreboard_empty", 32'd1, 32'd0);
        else check("hrdata", hrdata, exp_q.pop_front());
      end
`ifdef AHB_FIR_FIFO_IRQ_EN
      check("irq", {31'd0, irq}, {31'd0, m_irq});
`endif
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    hsel = 0; htrans = 2'b00; hwrite = 0;
  endtask

  task automatic addr_phase(input bit w, input int a);
    hsel = 1; htrans = 2'b10; hwrite = w; hsize = 3'b010;
    haddr = AWIDTH'(a) << 2;
  endtask

  task automatic ahb_read(input int a);
    addr_phase(0, a);
    step();
    set_idle();
    step();
  endtask

  task automatic ahb_write(input int a, input logic [DWIDTH-1:0] d, input bit we, input logic [OUT_SIZE-1:0] s);
    addr_phase(1, a);
    step();
    set_idle();
    hwdata = d;
    write_en = we;
    out_wave = s;
    step();
    write_en = 0;
  endtask

  task automatic push(input logic [OUT_SIZE-1:0] s);
    write_en = 1;
    out_wave = s;
    step();
    write_en = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    set_idle();
    write_en = 0;
    step(); step();
    rst_n = 1;
    step();
  endtask

  initial begin
    rst_n = 0; hsel = 0; haddr = '0; hsize = 3'b010; hwrite = 0; htrans = 2'b00;
    hwdata = '0; hready = 1; write_en = 0; out_wave = '0;
    m_init = 0;
    #1;
    do_reset();
    check("hreadyout", {31'd0, hreadyout}, 32'd1);
    check("hresp", {31'd0, hresp}, 32'd0);

    // 1: reset status, empty pop, underflow
    ahb_read(1);
    ahb_read(0);
    ahb_read(1);
    ahb_write(2, 32'h4, 0, '0);
    ahb_read(1);

    // 2: sign extension and order
    push(16'hFFFF);
    push(16'd5);
    push(16'h7FFF);
    ahb_read(1);
    repeat (3) ahb_read(0);
    ahb_read(1);

    // 3: overflow
    for (int i = 0; i < DEPTH + 2; i++) push(OUT_SIZE'($urandom));
    ahb_read(1);
    for (int i = 0; i < DEPTH; i++) ahb_read(0);
    ahb_read(1);
    ahb_write(2, 32'h2, 0, '0);
    ahb_read(1);

    // 4: full FIFO, concurrent push/pop across wrap
    for (int i = 0; i < DEPTH; i++) push(OUT_SIZE'($urandom));
    for (int i = 0; i <= DEPTH + 4; i++) begin
      if (i < DEPTH + 4) addr_phase(0, 0); else set_idle();
      write_en = (i > 0);
      out_wave = OUT_SIZE'($urandom);
      step();
    end
    write_en = 0;
    set_idle();
    step();
    ahb_read(1);

    // 5: flush beats same-cycle push
    ahb_write(2, 32'h1, 0, '0);
    for (int i = 0; i < 4; i++) push(OUT_SIZE'(i + 100));
    ahb_write(2, 32'h1, 1, 16'h1234);
    ahb_read(1);
    push(16'h0042);
    ahb_read(0);
    ahb_read(1);

`ifdef AHB_FIR_FIFO_IRQ_EN
    // 6: threshold interrupt
    ahb_write(3, 32'h4, 0, '0);
    ahb_read(3);
    for (int i = 0; i < 4; i++) push(OUT_SIZE'(i));
    step(); step();
    ahb_read(0);
    step(); step();
    ahb_write(3, 32'h0, 0, '0);
`endif

    // reset in the middle of a DATA read data phase
    push(16'h0777);
    addr_phase(0, 0);
    step();
    rst_n = 0;
    set_idle();
    step();
    rst_n = 1;
    step();
    ahb_read(1);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      hready = ($urandom_range(0, 7) != 0);
      hsel = ($urandom_range(0, 3) != 0);
      htrans = 2'($urandom_range(0, 3));
      hwrite = ($urandom_range(0, 4) == 0);
      haddr = AWIDTH'($urandom);
      hsize = 3'($urandom_range(0, 7));
      hwdata = DWIDTH'($urandom);
      if ($urandom_range(0, 15) != 0) hwdata[0] = 1'b0;
      write_en = ($urandom_range(0, 9) < 6);
      out_wave = OUT_SIZE'($urandom);
      step();
    end
    hready = 1;
    set_idle();
    write_en = 0;
    step();
    ahb_read(1);
    step();

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
